// File: rtl/pic_sequencer.sv
// Four-state FETCH/DECODE/EXECUTE/WRITEBACK sequencer for a small PIC-style core.
// Define SEQ_SKIP_EN to let skip_req squash the next instruction.
module pic_sequencer (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  prog_data,
  input  logic        prog_valid,
  input  logic        d,
  input  logic        branch,
  input  logic        skip_req,
  output logic [7:0]  inst_reg,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        w_we,
  output logic        f_we,
  output logic [1:0]  state,
  output logic        nop_active,
  output logic [15:0] retired
);

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    DECODE    = 2'b01,
    EXECUTE   = 2'b10,
    WRITEBACK = 2'b11
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  inst_q, inst_d;
  logic        nop_q, nop_d;
  logic        flush_q, flush_d;
  logic [15:0] retired_q, retired_d;
  logic        pc_inc_q, pc_inc_d;
  logic        pc_load_q, pc_load_d;
  logic        w_we_q, w_we_d;
  logic        f_we_q, f_we_d;
  logic        skip_en;

`ifdef SEQ_SKIP_EN
  assign skip_en = skip_req;
`else
  logic unused_skip;
  assign unused_skip = skip_req;
  assign skip_en     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FETCH;
      inst_q    <= 8'h00;
      nop_q     <= 1'b0;
      flush_q   <= 1'b0;
      retired_q <= 16'h0000;
      pc_inc_q  <= 1'b0;
      pc_load_q <= 1'b0;
      w_we_q    <= 1'b0;
      f_we_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      inst_q    <= inst_d;
      nop_q     <= nop_d;
      flush_q   <= flush_d;
      retired_q <= retired_d;
      pc_inc_q  <= pc_inc_d;
      pc_load_q <= pc_load_d;
      w_we_q    <= w_we_d;
      f_we_q    <= f_we_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH:     if (prog_valid) state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = WRITEBACK;
      WRITEBACK: state_d = FETCH;
      default:   state_d = FETCH;
    endcase
  end

  // Strobes are computed from the current state and land in flops,
  // so each is visible for exactly the cycle after its decode.
  always_comb begin
    inst_d    = inst_q;
    nop_d     = nop_q;
    flush_d   = flush_q;
    retired_d = retired_q;
    pc_inc_d  = 1'b0;
    pc_load_d = 1'b0;
    w_we_d    = 1'b0;
    f_we_d    = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (prog_valid) begin
          inst_d   = prog_data;
          nop_d    = flush_q;
          flush_d  = 1'b0;
          pc_inc_d = 1'b1;
        end
      end
      EXECUTE: begin
        if (!nop_q) begin
          if (branch) begin
            pc_load_d = 1'b1;
            flush_d   = 1'b1;
          end else if (skip_en) begin
            flush_d = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        if (!nop_q) begin
          w_we_d    = ~d;
          f_we_d    = d;
          retired_d = retired_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign inst_reg   = inst_q;
  assign pc_inc     = pc_inc_q;
  assign pc_load    = pc_load_q;
  assign w_we       = w_we_q;
  assign f_we       = f_we_q;
  assign state      = state_q;
  assign nop_active = nop_q;
  assign retired    = retired_q;

endmodule

// File: tb/tb_pic_sequencer.sv
// Directed bench for pic_sequencer: instruction table plus stall and
// mid-instruction reset sequences.
module tb_pic_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  prog_data;
  logic        prog_valid;
  logic        d;
  logic        branch;
  logic        skip_req;
  logic [7:0]  inst_reg;
  logic        pc_inc;
  logic        pc_load;
  logic        w_we;
  logic        f_we;
  logic [1:0]  state;
  logic        nop_active;
  logic [15:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef SEQ_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  pic_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .prog_data  (prog_data),
    .prog_valid (prog_valid),
    .d          (d),
    .branch     (branch),
    .skip_req   (skip_req),
    .inst_reg   (inst_reg),
    .pc_inc     (pc_inc),
    .pc_load    (pc_load),
    .w_we       (w_we),
    .f_we       (f_we),
    .state      (state),
    .nop_active (nop_active),
    .retired    (retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        d;
    logic        br;
    logic        sk;
    logic        nop;
    logic        pcl;
    logic        wwe;
    logic        fwe;
    logic [15:0] ret;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string name);
    check({name, " pc_inc"}, {31'd0, pc_inc}, 32'd0);
    check({name, " pc_load"}, {31'd0, pc_load}, 32'd0);
    check({name, " w_we"}, {31'd0, w_we}, 32'd0);
    check({name, " f_we"}, {31'd0, f_we}, 32'd0);
  endtask

  task automatic run_instr(input vec_t v, input int idx);
    string n;
    n = $sformatf("v%0d", idx);
    check({n, " start state"}, {30'd0, state}, 32'd0);
    prog_data  = v.data;
    prog_valid = 1'b1;
    d          = v.d;
    branch     = v.br;
    skip_req   = v.sk;
    tick();
    prog_valid = 1'b0;
    prog_data  = ~v.data;
    check({n, " decode state"}, {30'd0, state}, 32'd1);
    check({n, " inst_reg"}, {24'd0, inst_reg}, {24'd0, v.data});
    check({n, " pc_inc"}, {31'd0, pc_inc}, 32'd1);
    check({n, " nop_active"}, {31'd0, nop_active}, {31'd0, v.nop});
    check({n, " w_we c1"}, {31'd0, w_we}, 32'd0);
    prog_valid = 1'b1;
    tick();
    prog_valid = 1'b0;
    check({n, " exec state"}, {30'd0, state}, 32'd2);
    check_quiet({n, " c2"});
    tick();
    check({n, " wb state"}, {30'd0, state}, 32'd3);
    check({n, " pc_load"}, {31'd0, pc_load}, {31'd0, v.pcl});
    check({n, " w_we c3"}, {31'd0, w_we}, 32'd0);
    check({n, " f_we c3"}, {31'd0, f_we}, 32'd0);
    check({n, " inst_reg held"}, {24'd0, inst_reg}, {24'd0, v.data});
    tick();
    check({n, " fetch state"}, {30'd0, state}, 32'd0);
    check({n, " w_we"}, {31'd0, w_we}, {31'd0, v.wwe});
    check({n, " f_we"}, {31'd0, f_we}, {31'd0, v.fwe});
    check({n, " pc_load c4"}, {31'd0, pc_load}, 32'd0);
    check({n, " retired"}, {16'd0, retired}, {16'd0, v.ret});
  endtask

  function automatic vec_t mk(input logic [7:0] data, input logic dd,
                              input logic br, input logic sk,
                              input logic nop, input logic pcl,
                              input logic [15:0] ret);
    vec_t v;
    v.data = data;
    v.d    = dd;
    v.br   = br;
    v.sk   = sk;
    v.nop  = nop;
    v.pcl  = pcl;
    v.wwe  = !nop && !dd;
    v.fwe  = !nop && dd;
    v.ret  = ret;
    return v;
  endfunction

  initial begin
    vec_t r;
    reset      = 1'b1;
    prog_data  = 8'hFF;
    prog_valid = 1'b1;
    d          = 1'b1;
    branch     = 1'b1;
    skip_req   = 1'b1;

    // Expected retired counts are accumulated by hand per row
    vecs[0] = mk(8'h1D, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    vecs[1] = mk(8'hC0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd2);
    vecs[2] = mk(8'h39, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2);
    vecs[3] = mk(8'h07, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd3);
    vecs[4] = mk(8'h55, 1'b0, 1'b0, 1'b0, SKIP, 1'b0,
                 SKIP ? 16'd3 : 16'd4);
    vecs[5] = mk(8'hA1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1,
                 SKIP ? 16'd4 : 16'd5);
    vecs[6] = mk(8'h42, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0,
                 SKIP ? 16'd4 : 16'd5);
    vecs[7] = mk(8'h43, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                 SKIP ? 16'd5 : 16'd6);

    tick();
    tick();
    check("reset state", {30'd0, state}, 32'd0);
    check("reset inst_reg", {24'd0, inst_reg}, 32'd0);
    check("reset nop", {31'd0, nop_active}, 32'd0);
    check("reset retired", {16'd0, retired}, 32'd0);
    check_quiet("reset");

    reset      = 1'b0;
    prog_valid = 1'b0;
    branch     = 1'b0;
    skip_req   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d state", i), {30'd0, state}, 32'd0);
      check_quiet($sformatf("stall%0d", i));
    end

    for (int i = 0; i < 8; i++) run_instr(vecs[i], i);

    // Abort a branching instruction while it sits in EXECUTE
    prog_data  = 8'h99;
    prog_valid = 1'b1;
    d          = 1'b0;
    branch     = 1'b1;
    tick();
    prog_valid = 1'b0;
    tick();
    check("pre-abort state", {30'd0, state}, 32'd2);
    reset      = 1'b1;
    prog_valid = 1'b1;
    tick();
    reset      = 1'b0;
    prog_valid = 1'b0;
    check("abort state", {30'd0, state}, 32'd0);
    check("abort retired", {16'd0, retired}, 32'd0);
    check("abort inst_reg", {24'd0, inst_reg}, 32'd0);
    check_quiet("abort c0");
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("abort c%0d state", i), {30'd0, state}, 32'd0);
      check_quiet($sformatf("abort c%0d", i));
    end

    // Flush flag must not survive the reset
    r = mk(8'h2E, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1);
    run_instr(r, 8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
